// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
// Contents:
//   REG_AW_DEF - default register-index width
//   ZERO_REG   - index of the hard-wired zero register (never a real hazard)
//   state_t    - controller state (RUN, MEM_WAIT, HALT)
//   act_t      - the single action chosen each cycle; outputs and perf
//                strobes are both decoded from it so they cannot disagree
package pipe_ctrl_pkg;

  localparam int REG_AW_DEF = 5;
  localparam int ZERO_REG   = 0;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    HALT
  } state_t;

  typedef enum logic [2:0] {
    ACT_RESET,
    ACT_HALT,
    ACT_FREEZE,
    ACT_BRANCH,
    ACT_JUMP,
    ACT_STALL,
    ACT_PASS
  } act_t;

endpackage

// File: rtl/pipe_hazard_ctrl_perf_cnt.sv
// hazard_perf_cnt: three free-running performance counters for the pipeline
// sequencing controller. Each increments by one on its strobe and wraps
// modulo 2^CNT_W. Only instantiated when HAZ_PERF_CNT_EN is defined.
// Ports:
//   clk, res                     clock, async active-low reset (clears counts)
//   stall_inc, flush_inc, wait_inc  increment strobes
//   stall_cnt, flush_cnt, wait_cnt  counter values
module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             res,
  input  logic             stall_inc,
  input  logic             flush_inc,
  input  logic             wait_inc,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      if (stall_inc) stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc) flush_cnt <= flush_cnt + 1'b1;
      if (wait_inc)  wait_cnt  <= wait_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline sequencing controller for the 5-stage core.
// Drives per-stage pipeline-register write enables and flushes: load-use
// bubbles, wrong-path flushes on taken branches/jumps, whole-pipe freeze
// while a data-memory access waits, and a sticky HALT on access timeout.
// Outputs are Mealy (state + current inputs); state is registered.
// Optional feature: define HAZ_PERF_CNT_EN to add stall/flush/wait counters.
// Ports:
//   clk, res                 clock, async active-low reset
//   id_rs, id_rt, id_uses_rt ID-stage source operands
//   id_jump                  jump decoded in ID
//   ex_mem_read, ex_rt       load in EX and its destination
//   ex_branch_taken          branch in EX resolved taken
//   dmem_req, dmem_ack       MEM-stage access handshake
//   pc_we..exmem_we          pipeline-register write enables
//   ifid/idex/memwb_flush    insert a bubble into that register
//   halted, mem_err          HALT indication, sticky timeout flag
//   stall/flush/wait_cnt     perf counters (HAZ_PERF_CNT_EN only)
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW      = REG_AW_DEF,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              res,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              id_jump,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              ex_branch_taken,
  input  logic              dmem_req,
  input  logic              dmem_ack,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              idex_we,
  output logic              exmem_we,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              memwb_flush,
  output logic              halted,
  output logic              mem_err
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  wait_cnt
`endif
);

  localparam int TO_W = $clog2(MEM_TIMEOUT);

  if (MEM_TIMEOUT < 2 || CNT_W < 1) begin : g_bad_params
    $error("pipe_hazard_ctrl: MEM_TIMEOUT must be >= 2 and CNT_W >= 1");
  end

  state_t          state;
  logic [TO_W-1:0] to_cnt;
  logic            load_use;
  act_t            adv_act;
  act_t            act;

  // A load into r0 never produces a value, so it cannot cause a hazard.
  assign load_use = ex_mem_read && (ex_rt != REG_AW'(ZERO_REG)) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // Decision when the pipe is allowed to move. The branch outranks the
  // load-use check because the dependent instruction is on the wrong path.
  always_comb begin
    adv_act = ACT_PASS;
    if (ex_branch_taken)  adv_act = ACT_BRANCH;
    else if (id_jump)     adv_act = ACT_JUMP;
    else if (load_use)    adv_act = ACT_STALL;
  end

  always_comb begin
    act = ACT_PASS;
    if (!res) begin
      act = ACT_RESET;
    end else begin
      case (state)
        HALT:     act = ACT_HALT;
        MEM_WAIT: act = dmem_ack ? adv_act : ACT_FREEZE;
        default:  act = (dmem_req && !dmem_ack) ? ACT_FREEZE : adv_act;
      endcase
    end
  end

  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    idex_we     = 1'b1;
    exmem_we    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    halted      = 1'b0;
    case (act)
      ACT_RESET, ACT_HALT: begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_we     = 1'b0;
        exmem_we    = 1'b0;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        memwb_flush = 1'b1;
        halted      = (act == ACT_HALT);
      end
      ACT_FREEZE: begin
        // Everything holds; MEM/WB gets a bubble so the stalled access is
        // not retired repeatedly.
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_we     = 1'b0;
        exmem_we    = 1'b0;
        memwb_flush = 1'b1;
      end
      ACT_BRANCH: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end
      ACT_JUMP: begin
        ifid_flush = 1'b1;
      end
      ACT_STALL: begin
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        idex_flush = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state   <= RUN;
      to_cnt  <= '0;
      mem_err <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (dmem_req && !dmem_ack) begin
            state  <= MEM_WAIT;
            to_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (dmem_ack) begin
            state <= RUN;
          end else if (to_cnt == TO_W'(MEM_TIMEOUT - 1)) begin
            state   <= HALT;
            mem_err <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        HALT:    state <= HALT;
        default: state <= RUN;
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  hazard_perf_cnt #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk       (clk),
    .res       (res),
    .stall_inc (act == ACT_STALL),
    .flush_inc ((act == ACT_BRANCH) || (act == ACT_JUMP)),
    .wait_inc  (act == ACT_FREEZE),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt),
    .wait_cnt  (wait_cnt)
  );
`else
  // Counters are absent in this build.
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl. Expected output vectors are
// queued when each step is driven and popped when the step is sampled.
module tb_pipe_hazard_ctrl;

  localparam int REG_AW      = 5;
  localparam int MEM_TIMEOUT = 16;
  localparam int CNT_W       = 32;

  // {pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush, memwb_flush, halted, mem_err}
  localparam logic [8:0] E_RUN  = 9'b1111_000_0_0;
  localparam logic [8:0] E_FRZ  = 9'b0000_001_0_0;
  localparam logic [8:0] E_BR   = 9'b1111_110_0_0;
  localparam logic [8:0] E_JMP  = 9'b1111_100_0_0;
  localparam logic [8:0] E_LU   = 9'b0011_010_0_0;
  localparam logic [8:0] E_RST  = 9'b0000_111_0_0;
  localparam logic [8:0] E_HALT = 9'b0000_111_1_1;

  logic              clk = 1'b0;
  logic              res;
  logic [REG_AW-1:0] id_rs, id_rt, ex_rt;
  logic              id_uses_rt, id_jump, ex_mem_read, ex_branch_taken;
  logic              dmem_req, dmem_ack;
  logic              pc_we, ifid_we, idex_we, exmem_we;
  logic              ifid_flush, idex_flush, memwb_flush, halted, mem_err;
`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0]  stall_cnt, flush_cnt, wait_cnt;
`endif
  logic [8:0]        obs;

  int tests = 0;
  int fails = 0;

  logic [8:0] exp_q[$];
  string      tag_q[$];

  always #5 clk = ~clk;

  assign obs = {pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush,
                memwb_flush, halted, mem_err};

  pipe_hazard_ctrl #(
    .REG_AW(REG_AW), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .res(res),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_jump(id_jump),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we), .exmem_we(exmem_we),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_flush(memwb_flush),
    .halted(halted), .mem_err(mem_err)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
`endif
  );

  task automatic idle();
    id_rs = '0; id_rt = '0; ex_rt = '0;
    id_uses_rt = 1'b0; id_jump = 1'b0; ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; dmem_req = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic rand_in();
    id_rs = REG_AW'($urandom); id_rt = REG_AW'($urandom); ex_rt = REG_AW'($urandom);
    id_uses_rt = 1'($urandom); id_jump = 1'($urandom); ex_mem_read = 1'($urandom);
    ex_branch_taken = 1'($urandom); dmem_req = 1'($urandom); dmem_ack = 1'($urandom);
  endtask

  // Inputs are already driven; sample at the falling edge, then move past
  // the next rising edge.
  task automatic step(input logic [8:0] exp, input string tag);
    logic [8:0] e;
    string      t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    tests++;
    assert (obs === e) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", t, obs, e);
    end
    @(posedge clk);
    #1;
  endtask

`ifdef HAZ_PERF_CNT_EN
  task automatic check_cnt(input int s, input int f, input int w, input string tag);
    tests++;
    assert (stall_cnt === CNT_W'(s)) else begin
      fails++;
      $error("FAIL %s stall_cnt: observed %0d expected %0d", tag, stall_cnt, s);
    end
    tests++;
    assert (flush_cnt === CNT_W'(f)) else begin
      fails++;
      $error("FAIL %s flush_cnt: observed %0d expected %0d", tag, flush_cnt, f);
    end
    tests++;
    assert (wait_cnt === CNT_W'(w)) else begin
      fails++;
      $error("FAIL %s wait_cnt: observed %0d expected %0d", tag, wait_cnt, w);
    end
  endtask
`endif

  initial begin
    // Reset with random inputs for two cycles.
    res = 1'b0;
    rand_in();
    step(E_RST, "reset_0");
    rand_in();
    step(E_RST, "reset_1");
`ifdef HAZ_PERF_CNT_EN
    check_cnt(0, 0, 0, "reset_cnt");
`endif
    res = 1'b1;
    idle();
    step(E_RUN, "idle_after_reset");

    // Load-use via rs: exactly one bubble.
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    step(E_LU, "lu_rs");
    idle();
    step(E_RUN, "lu_rs_clear");

    // Load-use via rt when rt is read.
    ex_mem_read = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_uses_rt = 1'b1;
    step(E_LU, "lu_rt");
    // Same rt match but rt not read.
    id_uses_rt = 1'b0;
    step(E_RUN, "lu_rt_unused");
    // Load into r0 never stalls.
    idle();
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
    step(E_RUN, "lu_r0");
    // Matching register but EX is not a load.
    idle();
    ex_rt = 5'd12; id_rs = 5'd12;
    step(E_RUN, "no_load");
`ifdef HAZ_PERF_CNT_EN
    check_cnt(2, 0, 0, "after_lu");
`endif

    // Taken branch hides a load-use in the same cycle.
    idle();
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; ex_branch_taken = 1'b1;
    step(E_BR, "branch_lu");
`ifdef HAZ_PERF_CNT_EN
    check_cnt(2, 1, 0, "branch_lu_cnt");
`endif
    idle();
    id_jump = 1'b1;
    step(E_JMP, "jump");
    // Jump outranks load-use.
    ex_mem_read = 1'b1; ex_rt = 5'd4; id_rs = 5'd4;
    step(E_JMP, "jump_lu");
    // Branch outranks jump.
    idle();
    ex_branch_taken = 1'b1; id_jump = 1'b1;
    step(E_BR, "branch_jump");
    // Zero-wait access.
    idle();
    dmem_req = 1'b1; dmem_ack = 1'b1;
    step(E_RUN, "zero_wait");
`ifdef HAZ_PERF_CNT_EN
    check_cnt(2, 4, 0, "before_wait");
`endif

    // Access acked three cycles later, with a branch frozen in EX and a
    // load-use pattern present during the first frozen cycle.
    idle();
    dmem_req = 1'b1; ex_branch_taken = 1'b1;
    ex_mem_read = 1'b1; ex_rt = 5'd7; id_rs = 5'd7;
    step(E_FRZ, "wait_0");
    ex_mem_read = 1'b0;
    step(E_FRZ, "wait_1");
    step(E_FRZ, "wait_2");
    dmem_ack = 1'b1;
    step(E_BR, "wait_ack_branch");
    idle();
    step(E_RUN, "after_wait");
`ifdef HAZ_PERF_CNT_EN
    check_cnt(2, 5, 3, "after_wait_cnt");
`endif

    // Timeout: entry cycle plus MEM_TIMEOUT waiting cycles, then HALT.
    dmem_req = 1'b1;
    for (int i = 0; i <= MEM_TIMEOUT; i++) step(E_FRZ, "timeout_wait");
    step(E_HALT, "halt_0");
    dmem_ack = 1'b1; ex_branch_taken = 1'b1;
    step(E_HALT, "halt_ack");
    idle();
    step(E_HALT, "halt_idle");
`ifdef HAZ_PERF_CNT_EN
    check_cnt(2, 5, 3 + MEM_TIMEOUT + 1, "halt_hold");
`endif
    res = 1'b0;
    step(E_RST, "halt_reset");
`ifdef HAZ_PERF_CNT_EN
    check_cnt(0, 0, 0, "halt_reset_cnt");
`endif
    res = 1'b1;
    step(E_RUN, "halt_released");

    // Reset in the middle of a wait.
    dmem_req = 1'b1;
    for (int i = 0; i < 5; i++) step(E_FRZ, "midwait");
    res = 1'b0;
    step(E_RST, "midwait_reset");
    res = 1'b1;
    idle();
    step(E_RUN, "midwait_released");

    // Ack arriving in the last waiting cycle before the trap.
    dmem_req = 1'b1;
    for (int i = 0; i < MEM_TIMEOUT; i++) step(E_FRZ, "late_wait");
    dmem_ack = 1'b1;
    step(E_RUN, "late_ack");
    idle();
    step(E_RUN, "late_after");
    step(E_RUN, "late_after2");
`ifdef HAZ_PERF_CNT_EN
    check_cnt(0, 0, MEM_TIMEOUT, "late_cnt");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 32-bit 5-stage RISC core. It sits beside the main decode control unit and drives the per-stage pipeline-register write enables and flushes. It inserts load-use bubbles, flushes the wrong path on taken branches and jumps, and freezes the whole pipeline while a data-memory access waits for its acknowledge. A memory access that never completes is trapped into a sticky halt.

## Interface
Parameters:
- REG_AW, 5, register-index width
- MEM_TIMEOUT, 16, maximum number of MEM_WAIT cycles before the halt trap (≥2)
- CNT_W, 32, width of the performance counters

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- res  in  1  reset; asynchronous, active-low (0 = reset)
- id_rs  in  REG_AW  rs index of the instruction in ID
- id_rt  in  REG_AW  rt index of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt (R-type, beq, sw)
- id_jump  in  1  Jump from the control unit, instruction in ID
- ex_mem_read  in  1  MemRead of the instruction in EX
- ex_rt  in  REG_AW  destination rt of the instruction in EX
- ex_branch_taken  in  1  branch in EX resolved as taken
- dmem_req  in  1  MEM-stage load/store is active this cycle
- dmem_ack  in  1  data memory completes the access this cycle
- pc_we, ifid_we, idex_we, exmem_we  out  1  pipeline-register write enables
- ifid_flush, idex_flush, memwb_flush  out  1  load a bubble (NOP, all controls 0)
- halted  out  1  controller is in HALT
- mem_err  out  1  sticky timeout flag
- stall_cnt, flush_cnt, wait_cnt  out  CNT_W  perf counters (HAZ_PERF_CNT_EN only)

## Operation
- States: RUN, MEM_WAIT, HALT. State and counters are registered. Outputs are combinational (Mealy) from the state and the current inputs.
- Load-use hazard: `ex_mem_read && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt))`.
- RUN behaviour, highest priority first:
  1. Freeze: if dmem_req && !dmem_ack:
     - pc_we, ifid_we, idex_we and exmem_we are all 0; memwb_flush=1.
     - Next state is MEM_WAIT.
  2. Taken branch: if ex_branch_taken:
     - pc_we=1 (loads the target); ifid_flush=1; idex_flush=1.
     - Any load-use condition in the same cycle is ignored, because that instruction is on the wrong path.
  3. Jump: if id_jump: pc_we=1; ifid_flush=1. ID/EX advances normally.
  4. Load-use: pc_we=0; ifid_we=0; idex_flush=1. This inserts exactly one bubble, and the condition clears naturally the following cycle.
  5. Otherwise all write enables are 1 and all flushes are 0.
- dmem_req && dmem_ack in the same cycle is a zero-wait access: no freeze.
- MEM_WAIT:
  - Outputs are as for a freeze while dmem_ack=0.
  - The cycle dmem_ack=1 is evaluated exactly as RUN rules 2–5, and the next state is RUN. A branch held frozen in EX therefore flushes in the ack cycle.
- Timeout: the internal counter to_cnt is cleared on entry to MEM_WAIT and increments each MEM_WAIT cycle without an ack.
  - When to_cnt == MEM_TIMEOUT-1 and dmem_ack=0, the next state is HALT and mem_err is set.
- HALT:
  - All write enables are 0; all flushes are 1; halted=1.
  - Exit only by reset. mem_err stays 1 until reset.
- Reset (res=0, at any time, including mid-MEM_WAIT):
  - State=RUN; to_cnt=0; mem_err=0.
  - While res=0, outputs are forced: all write enables 0, all flushes 1, halted=0, and perf counters 0.
  - The first cycle after release follows RUN rules.

## Timing
- Zero-cycle decision latency: controls apply in the same cycle the inputs are presented.
- A load-use stall costs exactly 1 cycle.
- A taken branch costs 2 bubbles; a jump costs 1 bubble.
- An access that waits N cycles for its ack (N < MEM_TIMEOUT) freezes the pipeline for exactly N cycles.
- HALT is entered on the edge ending the MEM_TIMEOUT-th waiting cycle.

## Configuration
- HAZ_PERF_CNT_EN defined:
  - stall_cnt counts load-use bubbles.
  - flush_cnt counts branch and jump flush events.
  - wait_cnt counts freeze cycles (RUN entry cycle plus MEM_WAIT cycles without ack).
  - All counters wrap modulo 2^CNT_W and hold in HALT.
- HAZ_PERF_CNT_EN undefined: the three ports and their registers are absent; all other behaviour is identical.

## Structure
- Package pipe_ctrl_pkg holds:
  - the state enum (RUN, MEM_WAIT, HALT)
  - the REG_AW default
  - the zero-register index constant
- Sub-module hazard_perf_cnt holds the three counters. It takes increment strobes from the controller and is instantiated only under HAZ_PERF_CNT_EN.

## Test plan
- Reset: hold res=0 for 2 cycles with random inputs → all write enables 0, flushes 1; after release, idle inputs give all write enables 1.
- Load-use: ex_mem_read=1, ex_rt=8, id_rs=8 → exactly 1 cycle with pc_we=0, ifid_we=0, idex_flush=1. With ex_rt=0 → no stall.
- Branch with load-use: ex_branch_taken=1 in the same cycle as a load-use hazard → pc_we=1, ifid_flush=1, idex_flush=1, stall_cnt unchanged, flush_cnt+1.
- Memory wait: dmem_req=1 with ack 3 cycles later → 3 frozen cycles with memwb_flush=1, then advance; wait_cnt=3.
- Timeout: MEM_TIMEOUT=16, dmem_req=1, never ack → HALT after 16 waiting cycles, mem_err=1 and halted=1. Asserting res=0 mid-wait in a separate run returns to RUN with mem_err=0.
